// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I pipeline hazard logic: result-select codes,
// forwarding mux selects and the memory-wait FSM states.
package riscv_pkg;

    localparam logic [1:0] RESULT_LOAD = 2'b01;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } wait_state_e;

    // M-stage producer wins over W-stage; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic       regw_m,
        input logic [4:0] rd_m,
        input logic       regw_w,
        input logic [4:0] rd_w,
        input logic [4:0] rs
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (regw_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = FWD_M;
        end else if (regw_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_shadow.sv
// Shadow copy of the E/M/W register addresses and control bits used for
// hazard detection; mirrors the real pipeline's hold/flush/bubble behaviour.
module hazard_shadow
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       hold,
    input  logic       flush_e,
    input  logic [4:0] rs1_in,
    input  logic [4:0] rs2_in,
    input  logic [4:0] rd_in,
    input  logic       regw_in,
    input  logic       load_in,
    output logic [4:0] rs1_e,
    output logic [4:0] rs2_e,
    output logic [4:0] rd_e,
    output logic       load_e,
    output logic [4:0] rd_m,
    output logic       regw_m,
    output logic [4:0] rd_w,
    output logic       regw_w
);

    logic [4:0] rs1_e_q, rs1_e_d;
    logic [4:0] rs2_e_q, rs2_e_d;
    logic [4:0] rd_e_q,  rd_e_d;
    logic       regw_e_q, regw_e_d;
    logic       load_e_q, load_e_d;
    logic [4:0] rd_m_q,  rd_m_d;
    logic       regw_m_q, regw_m_d;
    logic [4:0] rd_w_q,  rd_w_d;
    logic       regw_w_q, regw_w_d;

    always_comb begin
        rs1_e_d  = rs1_e_q;
        rs2_e_d  = rs2_e_q;
        rd_e_d   = rd_e_q;
        regw_e_d = regw_e_q;
        load_e_d = load_e_q;
        rd_m_d   = rd_m_q;
        regw_m_d = regw_m_q;
        rd_w_d   = 5'd0;
        regw_w_d = 1'b0;
        // While frozen, E and M hold and a bubble drains into W.
        if (!hold) begin
            if (flush_e) begin
                rs1_e_d  = 5'd0;
                rs2_e_d  = 5'd0;
                rd_e_d   = 5'd0;
                regw_e_d = 1'b0;
                load_e_d = 1'b0;
            end else begin
                rs1_e_d  = rs1_in;
                rs2_e_d  = rs2_in;
                rd_e_d   = rd_in;
                regw_e_d = regw_in;
                load_e_d = load_in;
            end
            rd_m_d   = rd_e_q;
            regw_m_d = regw_e_q;
            rd_w_d   = rd_m_q;
            regw_w_d = regw_m_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rs1_e_q  <= 5'd0;
            rs2_e_q  <= 5'd0;
            rd_e_q   <= 5'd0;
            regw_e_q <= 1'b0;
            load_e_q <= 1'b0;
            rd_m_q   <= 5'd0;
            regw_m_q <= 1'b0;
            rd_w_q   <= 5'd0;
            regw_w_q <= 1'b0;
        end else begin
            rs1_e_q  <= rs1_e_d;
            rs2_e_q  <= rs2_e_d;
            rd_e_q   <= rd_e_d;
            regw_e_q <= regw_e_d;
            load_e_q <= load_e_d;
            rd_m_q   <= rd_m_d;
            regw_m_q <= regw_m_d;
            rd_w_q   <= rd_w_d;
            regw_w_q <= regw_w_d;
        end
    end

    assign rs1_e  = rs1_e_q;
    assign rs2_e  = rs2_e_q;
    assign rd_e   = rd_e_q;
    assign load_e = load_e_q;
    assign rd_m   = rd_m_q;
    assign regw_m = regw_m_q;
    assign rd_w   = rd_w_q;
    assign regw_w = regw_w_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage RV32I pipeline: forwarding,
// load-use stalls, branch flushes and a timed freeze on slow data memory.
module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdD,
    input  logic             RegWriteD,
    input  logic [1:0]       ResultSrcD,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             StallE,
    output logic             FlushE,
    output logic             StallM,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCycles
);

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);

    wait_state_e    state_q, state_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [4:0] rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       load_e, regw_m, regw_w;
    logic       timeout, mem_stall, lw_stall, flush_e;

    hazard_shadow u_shadow (
        .clk     (clk),
        .reset   (reset),
        .hold    (mem_stall),
        .flush_e (flush_e),
        .rs1_in  (Rs1D),
        .rs2_in  (Rs2D),
        .rd_in   (RdD),
        .regw_in (RegWriteD),
        .load_in (ResultSrcD == RESULT_LOAD),
        .rs1_e   (rs1_e),
        .rs2_e   (rs2_e),
        .rd_e    (rd_e),
        .load_e  (load_e),
        .rd_m    (rd_m),
        .regw_m  (regw_m),
        .rd_w    (rd_w),
        .regw_w  (regw_w)
    );

    always_comb begin
        timeout = (state_q == WAIT) && (wait_cnt_q == WCW'(MEM_TIMEOUT - 1));
        if (state_q == IDLE) begin
            mem_stall = MemReqM && !MemReadyM;
        end else begin
            mem_stall = !MemReadyM && !timeout;
        end
        lw_stall = load_e && (rd_e != 5'd0) && ((rd_e == Rs1D) || (rd_e == Rs2D));
        flush_e  = (lw_stall || PCSrcE) && !mem_stall;
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        case (state_q)
            IDLE: begin
                if (MemReqM && !MemReadyM) begin
                    state_d    = WAIT;
                    wait_cnt_d = WCW'(1);
                end
            end
            WAIT: begin
                if (MemReadyM) begin
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                end else if (timeout) begin
                    // Access is abandoned; the pipe moves on and the error sticks.
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                    mem_err_d  = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((lw_stall || mem_stall) && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallF      = lw_stall || mem_stall;
    assign StallD      = lw_stall || mem_stall;
    assign FlushD      = PCSrcE && !mem_stall;
    assign StallE      = mem_stall;
    assign FlushE      = flush_e;
    assign StallM      = mem_stall;
    assign FlushW      = mem_stall;
    assign ForwardAE   = fwd_sel(regw_m, rd_m, regw_w, rd_w, rs1_e);
    assign ForwardBE   = fwd_sel(regw_m, rd_m, regw_w, rd_w, rs2_e);
    assign MemErr      = mem_err_q;
    assign StallCycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a vector table for single-cycle behaviour
// plus hand sequences for timeout and reset during a memory wait.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic        RegWriteD;
    logic [1:0]  ResultSrcD;
    logic        PCSrcE, MemReqM, MemReadyM;
    logic        StallF, StallD, FlushD, StallE, FlushE, StallM, FlushW;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        MemErr;
    logic [31:0] StallCycles;

    int pass_cnt = 0;
    int total_cnt = 0;

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .RdD         (RdD),
        .RegWriteD   (RegWriteD),
        .ResultSrcD  (ResultSrcD),
        .PCSrcE      (PCSrcE),
        .MemReqM     (MemReqM),
        .MemReadyM   (MemReadyM),
        .StallF      (StallF),
        .StallD      (StallD),
        .FlushD      (FlushD),
        .StallE      (StallE),
        .FlushE      (FlushE),
        .StallM      (StallM),
        .FlushW      (FlushW),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .MemErr      (MemErr),
        .StallCycles (StallCycles)
    );

    always #5 clk = ~clk;

    // ctl packs {StallF, StallD, FlushD, StallE, FlushE, StallM, FlushW}
    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rw;
        logic [1:0] rsrc;
        logic       pc;
        logic       mr;
        logic       my;
        logic [6:0] ctl;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [31:0] cnt;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    function automatic vec_t mk(
        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
        input logic rw, input logic [1:0] rsrc, input logic pc,
        input logic mr, input logic my, input logic [6:0] ctl,
        input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] cnt
    );
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.rw = rw; v.rsrc = rsrc;
        v.pc = pc; v.mr = mr; v.my = my; v.ctl = ctl;
        v.fa = fa; v.fb = fb; v.cnt = cnt;
        return v;
    endfunction

    function automatic logic [6:0] ctl_now();
        return {StallF, StallD, FlushD, StallE, FlushE, StallM, FlushW};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic rw, input logic [1:0] rsrc, input logic pc,
                         input logic mr, input logic my);
        Rs1D = rs1; Rs2D = rs2; RdD = rd; RegWriteD = rw; ResultSrcD = rsrc;
        PCSrcE = pc; MemReqM = mr; MemReadyM = my;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = mk(0, 0, 5, 1, 2'b00, 0, 0, 0, 7'b0000000, 2'b00, 2'b00, 0);
        vecs[1]  = mk(5, 0, 6, 1, 2'b00, 0, 0, 0, 7'b0000000, 2'b00, 2'b00, 0);
        vecs[2]  = mk(0, 5, 0, 0, 2'b00, 0, 0, 0, 7'b0000000, 2'b10, 2'b00, 0);
        vecs[3]  = mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 7'b0000000, 2'b00, 2'b01, 0);
        vecs[4]  = mk(0, 0, 7, 1, 2'b01, 0, 0, 0, 7'b0000000, 2'b00, 2'b00, 0);
        vecs[5]  = mk(7, 0, 8, 1, 2'b00, 0, 0, 0, 7'b1100100, 2'b00, 2'b00, 0);
        vecs[6]  = mk(7, 0, 8, 1, 2'b00, 0, 0, 0, 7'b0000000, 2'b00, 2'b00, 1);
        vecs[7]  = mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 7'b0000000, 2'b01, 2'b00, 1);
        vecs[8]  = mk(0, 0, 0, 1, 2'b01, 0, 0, 0, 7'b0000000, 2'b00, 2'b00, 1);
        vecs[9]  = mk(0, 0, 9, 1, 2'b00, 0, 0, 0, 7'b0000000, 2'b00, 2'b00, 1);
        vecs[10] = mk(0, 0, 0, 0, 2'b00, 1, 0, 0, 7'b0010100, 2'b00, 2'b00, 1);
        vecs[11] = mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 7'b0000000, 2'b00, 2'b00, 1);
        vecs[12] = mk(0, 0, 0, 0, 2'b00, 0, 1, 0, 7'b1101011, 2'b00, 2'b00, 1);
        vecs[13] = mk(0, 0, 0, 0, 2'b00, 1, 1, 0, 7'b1101011, 2'b00, 2'b00, 2);
        vecs[14] = mk(0, 0, 0, 0, 2'b00, 0, 1, 0, 7'b1101011, 2'b00, 2'b00, 3);
        vecs[15] = mk(0, 0, 0, 0, 2'b00, 1, 1, 1, 7'b0010100, 2'b00, 2'b00, 4);
        vecs[16] = mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 7'b0000000, 2'b00, 2'b00, 4);
        vecs[17] = mk(0, 0, 3, 1, 2'b01, 0, 0, 0, 7'b0000000, 2'b00, 2'b00, 4);
        vecs[18] = mk(0, 3, 0, 0, 2'b00, 1, 0, 0, 7'b1110100, 2'b00, 2'b00, 4);
        vecs[19] = mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 7'b0000000, 2'b00, 2'b00, 5);

        reset = 1'b1;
        drive(0, 0, 0, 0, 2'b00, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset ctl", 32'(ctl_now()), 32'h0);
        chk("reset fwd", 32'({ForwardAE, ForwardBE}), 32'h0);
        chk("reset err", 32'(MemErr), 32'h0);
        chk("reset cnt", StallCycles, 32'h0);
        next_cycle();

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].rw, vecs[i].rsrc,
                  vecs[i].pc, vecs[i].mr, vecs[i].my);
            @(negedge clk);
            chk($sformatf("v%0d ctl", i), 32'(ctl_now()), 32'(vecs[i].ctl));
            chk($sformatf("v%0d fwdA", i), 32'(ForwardAE), 32'(vecs[i].fa));
            chk($sformatf("v%0d fwdB", i), 32'(ForwardBE), 32'(vecs[i].fb));
            chk($sformatf("v%0d cnt", i), StallCycles, vecs[i].cnt);
            chk($sformatf("v%0d err", i), 32'(MemErr), 32'h0);
            next_cycle();
        end

        // Timeout with MEM_TIMEOUT=4: three frozen cycles, released on the fourth.
        drive(0, 0, 0, 0, 2'b00, 0, 1, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("to%0d ctl", c), 32'(ctl_now()), 32'h6B);
            next_cycle();
        end
        @(negedge clk);
        chk("to release ctl", 32'(ctl_now()), 32'h0);
        chk("to release err", 32'(MemErr), 32'h0);
        chk("to release cnt", StallCycles, 32'd8);
        next_cycle();
        drive(0, 0, 0, 0, 2'b00, 0, 0, 0);
        @(negedge clk);
        chk("to err set", 32'(MemErr), 32'h1);
        chk("to idle ctl", 32'(ctl_now()), 32'h0);
        next_cycle();
        @(negedge clk);
        chk("to err sticky", 32'(MemErr), 32'h1);
        chk("to cnt hold", StallCycles, 32'd8);
        next_cycle();

        // Reset asserted on the second cycle of a wait.
        drive(0, 0, 0, 0, 2'b00, 0, 1, 0);
        @(negedge clk);
        chk("rw stall", 32'(ctl_now()), 32'h6B);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        drive(0, 0, 0, 0, 2'b00, 0, 0, 0);
        @(negedge clk);
        chk("rw ctl", 32'(ctl_now()), 32'h0);
        chk("rw fwd", 32'({ForwardAE, ForwardBE}), 32'h0);
        chk("rw err", 32'(MemErr), 32'h0);
        chk("rw cnt", StallCycles, 32'h0);
        next_cycle();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
